// File: rtl/fifo_rr_drain_arb.sv
// ---------------------------------------------------------------------------
// fifo_rr_drain_arb
//
// Round-robin read scheduler that drains NUM_CH synchronous FIFOs into one
// valid/ready output stream. Each FIFO is read through its read_en/empty/
// data_out pins; data_out is registered inside the FIFO and is valid one
// cycle after the accepted read strobe.
//
// Handshake: m_valid rises only once a word has been captured. While
// m_valid=1 and m_ready=0, m_data and m_ch are held. A word is transferred
// on every rising edge where m_valid && m_ready. m_ready is ignored while
// m_valid=0.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   arb_en        permits new grants (an in-flight transfer always finishes)
//   fifo_empty    per-channel empty flags
//   fifo_data     per-channel data_out, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_read_en  one-hot read strobe, only asserted in ISSUE
//   m_valid/m_ready/m_data/m_ch  output stream and source channel
//   busy          high whenever the FSM is not idle
//   dbg_state     current FSM state (IDLE=0, ISSUE=1, WAIT=2, OUT=3)
//
// Optional build macro FIFO_RR_DRAIN_ARB_CNT_EN adds:
//   xfer_cnt [15:0]   wrapping count of output handshakes
//   ch_stall [NUM_CH-1:0]  channel non-empty for 64 cycles without a grant
// ---------------------------------------------------------------------------
module fifo_rr_drain_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arb_en,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_CH-1:0]            fifo_read_en,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_ch,
    output logic                         busy,
    output logic [1:0]                   dbg_state
`ifdef FIFO_RR_DRAIN_ARB_CNT_EN
    ,output logic [15:0]                 xfer_cnt
    ,output logic [NUM_CH-1:0]           ch_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CH_W-1:0]       r_grant;
    logic [CH_W-1:0]       r_last_grant;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [CH_W-1:0]       r_m_ch;

    logic                  w_any;
    logic                  w_found;
    logic [CH_W-1:0]       w_pick;
    logic [CH_W-1:0]       w_idx;
    logic                  w_grant_evt;
    logic [NUM_CH-1:0]     w_onehot;
    logic [DATA_WIDTH-1:0] w_sel;

    assign w_any       = ~(&fifo_empty);
    assign w_grant_evt = (r_state == IDLE) && arb_en && w_any;

    // Rotating priority search: candidates are last_grant+1 .. last_grant+NUM_CH
    // taken modulo NUM_CH, so non-power-of-two channel counts wrap correctly.
    always_comb begin
        w_pick  = r_last_grant;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_W'((int'(r_last_grant) + k) % NUM_CH);
            if (!w_found && !fifo_empty[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant == CH_W'(i)) begin
                w_sel = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant;

    always_comb begin
        w_next_state = r_state;
        fifo_read_en = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_evt) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                // A granted FIFO that reads empty here is abandoned without a strobe.
                if (fifo_empty[r_grant]) begin
                    w_next_state = IDLE;
                end else begin
                    fifo_read_en = w_onehot;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                w_next_state = OUT;
            end
            OUT: begin
                if (r_m_valid && m_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_ch       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_evt) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
            end
            if (r_state == WAIT) begin
                r_m_data  <= w_sel;
                r_m_ch    <= r_grant;
                r_m_valid <= 1'b1;
            end else if (r_state == OUT && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_ch      = r_m_ch;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

`ifdef FIFO_RR_DRAIN_ARB_CNT_EN
    logic [15:0]       r_xfer_cnt;
    logic [NUM_CH-1:0] r_ch_stall;
    logic [5:0]        r_stall_cnt [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
            r_ch_stall <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_stall_cnt[i] <= '0;
            end
        end else begin
            if (r_m_valid && m_ready) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            // Saturating wait counter per channel; the 64th consecutive
            // non-empty cycle without a grant raises the stall flag.
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_grant_evt && (w_pick == CH_W'(i))) begin
                    r_stall_cnt[i] <= '0;
                    r_ch_stall[i]  <= 1'b0;
                end else if (fifo_empty[i]) begin
                    r_stall_cnt[i] <= '0;
                end else if (r_stall_cnt[i] != 6'd63) begin
                    r_stall_cnt[i] <= r_stall_cnt[i] + 6'd1;
                end else begin
                    r_ch_stall[i] <= 1'b1;
                end
            end
        end
    end

    assign xfer_cnt = r_xfer_cnt;
    assign ch_stall = r_ch_stall;
`endif

endmodule

// File: doc/fifo_rr_drain_arb.md
Name: fifo_rr_drain_arb

Overview:
- Round-robin read scheduler that drains NUM_CH instances of the team's synchronous FIFO into one output stream with a valid/ready handshake.
- Each FIFO is driven through its read_en, empty and data_out pins; data_out is registered and valid one cycle after an accepted read.
- Sits between the per-source FIFOs and the single downstream consumer, and is the sole reader of every attached FIFO.

Parameters:
- DATA_WIDTH, 8: width of each FIFO word and of m_data.
- NUM_CH, 4: number of FIFOs arbitrated (2..16); CH_W = $clog2(NUM_CH).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- arb_en  input  1  permits new grants; an in-flight transfer always completes.
- fifo_empty  input  NUM_CH  empty flag of each FIFO; bit i is channel i.
- fifo_data  input  NUM_CH*DATA_WIDTH  data_out of each FIFO; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_read_en  output  NUM_CH  one-hot read strobe to the FIFOs.
- m_valid  output  1  output word valid.
- m_ready  input  1  consumer accepts the word.
- m_data  output  DATA_WIDTH  output word.
- m_ch  output  CH_W  source channel of m_data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE; grant=0; last_grant=NUM_CH-1, so channel 0 wins first; m_valid=0; m_data=0; m_ch=0; fifo_read_en=0; busy=0.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - If arb_en=1 and any fifo_empty bit is 0, pick the first non-empty channel searching upward from last_grant+1, modulo NUM_CH.
  - Register that channel into grant and last_grant, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - fifo_read_en = onehot(grant), decoded combinationally from the registered grant.
  - fifo_read_en is 0 in every other state.
  - If fifo_empty[grant]=1 (defensive case, not expected), drive no strobe and return to IDLE.
  - Otherwise go to WAIT.
- WAIT:
  - The FIFO's data_out is valid this cycle.
  - At the clock edge: m_data <= fifo_data[grant], m_ch <= grant, m_valid <= 1.
  - Go to OUT.
- OUT:
  - m_valid=1; m_data and m_ch are held stable while m_ready=0.
  - On m_valid && m_ready: m_valid <= 0 and go to IDLE.
- Latency: a non-empty FIFO seen in IDLE at cycle 0 gives read_en at cycle 1, m_valid at cycle 3 and the earliest accept at cycle 3.
- Throughput: at most 1 word per 4 cycles.
- Fairness:
  - last_grant updates only when a grant is made.
  - A channel that stays non-empty is served at least once every NUM_CH grants.
- Exactly one fifo_read_en bit is high at a time; at most one read is outstanding.
- arb_en=0 mid-transfer: the transfer finishes normally; the block then holds in IDLE.
- Reset asserted mid-operation: all state and outputs return to reset values immediately and asynchronously. The word being read is lost; the attached FIFOs are reset by the same rst_n.
- Wrap: the search from last_grant=NUM_CH-1 starts at channel 0. The search is a pure modulo-NUM_CH rotation, correct for non-power-of-two NUM_CH.
- m_ready is ignored outside OUT.

Optional Feature:
- Macro: FIFO_RR_DRAIN_ARB_CNT_EN.
- Defined:
  - Adds output xfer_cnt [15:0], reset to 0.
  - xfer_cnt increments by 1 on each m_valid && m_ready and wraps 0xFFFF -> 0.
  - Adds output ch_stall [NUM_CH-1:0]. Bit i is registered high when channel i has been non-empty for 64 consecutive cycles without a grant, and clears on its next grant.
- Not defined: neither port exists and no counter logic is synthesized.

Test Plan:
- Reset, then load ch0 with 0xA1 and hold m_ready=1 -> read_en=4'b0001 at cycle 1; m_valid at cycle 3 with m_data=0xA1, m_ch=0; busy low at cycle 4.
- All 4 FIFOs hold 2 words (ch i holds 0x10+i then 0x20+i), m_ready=1 -> output order ch 0,1,2,3,0,1,2,3 with data 0x10..0x13 then 0x20..0x23; never two read_en bits high.
- Only ch2 and ch3 non-empty after a grant to ch3 -> next grant goes to ch2 (wrap through 0 and 1, skipping empty channels).
- Word 0x5C in OUT with m_ready=0 for 10 cycles -> m_valid=1 and m_data=0x5C, m_ch stable throughout; no read_en pulses; accept on the cycle m_ready rises.
- arb_en dropped during WAIT with ch1 still non-empty -> the current word is delivered; no further read_en while arb_en=0; grants resume one cycle after arb_en returns high.
- rst_n pulsed low during OUT -> m_valid=0 and state IDLE immediately. With FIFO_RR_DRAIN_ARB_CNT_EN defined, xfer_cnt returns to 0; after 3 handshakes it reads 3.
